// File: rtl/featuremap_pkg.sv
// -----------------------------------------------------------------------------
// featuremap_pkg
// Shared definitions for the featuremap frame sequencer and the padded raster
// counters reused by the pooling-layer padders.
//   - state encodings (legacy constants) and the sequencer state enum
//   - fm_clog2: ceil(log2(v)) for sizing counters from parameters
//   - padded_size: number of positions in a 1-pixel zero-bordered frame
// -----------------------------------------------------------------------------
package featuremap_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FEED  = ST_FEED,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

    function automatic int unsigned fm_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned padded_size(input int unsigned w,
                                                input int unsigned h);
        return (w + 2) * (h + 2);
    endfunction

endpackage

// File: rtl/pad_raster_counter.sv
// -----------------------------------------------------------------------------
// pad_raster_counter
// Raster-order position counter over a (WIDTH+2)x(HEIGHT+2) padded frame.
// Ports:
//   clk      clock
//   rst      synchronous reset, active-low (position -> 0,0)
//   clear    synchronous return to position (0,0)
//   advance  step to the next raster position
//   row/col  current padded position
//   border   current position lies on the 1-pixel zero border
//   last     current position is the final one, (HEIGHT+1, WIDTH+1)
// -----------------------------------------------------------------------------
module pad_raster_counter
    import featuremap_pkg::*;
#(
    parameter int unsigned WIDTH  = 56,
    parameter int unsigned HEIGHT = 56
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              advance,
    output logic [fm_clog2(HEIGHT+2)-1:0]     row,
    output logic [fm_clog2(WIDTH+2)-1:0]      col,
    output logic                              border,
    output logic                              last
);

    localparam int unsigned ROW_W = fm_clog2(HEIGHT + 2);
    localparam int unsigned COL_W = fm_clog2(WIDTH + 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH + 1);

    logic row_last;
    logic col_last;

    assign row_last = (row == ROW_LAST);
    assign col_last = (col == COL_LAST);
    assign border   = (row == '0) | row_last | (col == '0) | col_last;
    assign last     = row_last & col_last;

    // Advancing past the final position wraps to (0,0) so the counter is
    // ready for the next frame without an explicit clear.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/featuremap_stream_ctrl.sv
// -----------------------------------------------------------------------------
// featuremap_stream_ctrl
// Frame sequencer for one conv layer: reads NUM_CH show-ahead channel FIFOs in
// lockstep, inserts a 1-pixel zero border to form a (WIDTH+2)x(HEIGHT+2)
// raster stream, counts result pixels returned by the bias adder and flags
// frame completion.
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   start        one-cycle pulse, begins a frame when idle
//   fifo_empty   per-channel empty flags
//   fifo_data    channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   fifo_rdreq   common read request to all channel FIFOs
//   pix_data     padded pixel, same packing as fifo_data
//   pix_valid    pix_data valid this cycle
//   res_valid    result pixel valid from the bias adder
//   busy         frame in progress (state != IDLE)
//   frame_done   one-cycle pulse after the last result
//   err_overrun  sticky: unexpected res_valid observed
// -----------------------------------------------------------------------------
module featuremap_stream_ctrl
    import featuremap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned WIDTH      = 56,
    parameter int unsigned HEIGHT     = 56
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_CH-1:0]            fifo_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
    output logic                         fifo_rdreq,
    output logic [NUM_CH*DATA_WIDTH-1:0] pix_data,
    output logic                         pix_valid,
    input  logic                         res_valid,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_overrun
);

    localparam int unsigned NUM_RES = WIDTH * HEIGHT;
    localparam int unsigned CNT_W   = fm_clog2(NUM_RES + 1);
    localparam logic [CNT_W-1:0] RES_FULL = CNT_W'(NUM_RES);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]              res_cnt;
    logic [CNT_W-1:0]              res_cnt_next;
    logic                          res_count_en;
    logic                          res_reject;
    logic                          issue;
    logic                          pos_border;
    logic                          pos_last;
    logic [fm_clog2(HEIGHT+2)-1:0] pos_row;
    logic [fm_clog2(WIDTH+2)-1:0]  pos_col;

    pad_raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .advance (issue),
        .row     (pos_row),
        .col     (pos_col),
        .border  (pos_border),
        .last    (pos_last)
    );

    // A read only happens with every channel non-empty, keeping the
    // channels in lockstep; border positions never touch the FIFOs.
    assign fifo_rdreq = (state == FEED) & ~pos_border & ~|fifo_empty;
    assign issue      = (state == FEED) & (pos_border | fifo_rdreq);

    assign res_count_en = res_valid & ((state == FEED) | (state == DRAIN))
                        & (res_cnt != RES_FULL);
    assign res_reject   = res_valid & ~res_count_en;
    assign res_cnt_next = res_cnt + CNT_W'(res_count_en);

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = FEED;
            FEED:  if (issue && pos_last)
                       state_next = (res_cnt_next == RES_FULL) ? DONE : DRAIN;
            DRAIN: if (res_cnt_next == RES_FULL) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            res_cnt     <= '0;
            err_overrun <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
        end else begin
            state       <= state_next;
            res_cnt     <= (state == IDLE) ? '0 : res_cnt_next;
            err_overrun <= err_overrun | res_reject;
            // Border zeros and FIFO words share this register stage, so the
            // raster order on the output matches the position order.
            pix_valid   <= issue;
            pix_data    <= fifo_rdreq ? fifo_data : '0;
        end
    end

    // Leaving the final position wraps the counter, so DRAIN always sits at (0,0).
    always_ff @(posedge clk) begin
        if (rst && state == DRAIN) begin
            assert (pos_row == '0 && pos_col == '0);
        end
    end

endmodule

// File: tb/tb_featuremap_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_featuremap_stream_ctrl
// Directed sequence with random FIFO contents for featuremap_stream_ctrl at
// WIDTH=4, HEIGHT=3, NUM_CH=8. Expected streams are derived from the padded
// raster definition (border -> zero, interior -> next FIFO word in order).
// -----------------------------------------------------------------------------
module tb_featuremap_stream_ctrl;
    import featuremap_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned NCH  = 8;
    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int NPIX = int'(padded_size(W, H));
    localparam int NINT = int'(W * H);
    localparam int MEMN = 64;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               res_valid = 1'b0;
    logic [NCH-1:0]     starve_mask = '0;
    logic [NCH-1:0]     fifo_empty;
    logic [NCH*DW-1:0]  fifo_data;
    logic [NCH*DW-1:0]  pix_data;
    logic               fifo_rdreq;
    logic               pix_valid;
    logic               busy;
    logic               frame_done;
    logic               err_overrun;

    logic [NCH*DW-1:0]  mem [MEMN];
    logic [6:0]         rd_ptr = '0;
    int                 cyc = 0;

    logic [NCH*DW-1:0]  got_data[$];
    int                 got_cyc[$];
    int                 rd_count = 0;
    int                 done_count = 0;
    int                 done_cyc = -1;

    int passed = 0;
    int total  = 0;

    featuremap_stream_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .WIDTH      (W),
        .HEIGHT     (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .fifo_empty  (fifo_empty),
        .fifo_data   (fifo_data),
        .fifo_rdreq  (fifo_rdreq),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .res_valid   (res_valid),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model shared by all channels (lockstep words).
    assign fifo_data  = mem[rd_ptr[5:0]];
    assign fifo_empty = rd_ptr[6] ? '1 : starve_mask;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rdreq) rd_ptr <= rd_ptr + 7'd1;
    end

    always @(negedge clk) begin
        if (pix_valid) begin
            got_data.push_back(pix_data);
            got_cyc.push_back(cyc);
        end
        if (fifo_rdreq) rd_count = rd_count + 1;
        if (frame_done) begin
            done_count = done_count + 1;
            done_cyc   = cyc;
        end
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [NCH*DW-1:0] obs,
                           input logic [NCH*DW-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bit({tag, "_pix_valid"}, pix_valid, 1'b0);
        chk_vec({tag, "_pix_data"}, pix_data, '0);
        chk_bit({tag, "_rdreq"}, fifo_rdreq, 1'b0);
        chk_bit({tag, "_busy"}, busy, 1'b0);
        chk_bit({tag, "_frame_done"}, frame_done, 1'b0);
        chk_bit({tag, "_err"}, err_overrun, 1'b0);
    endtask

    // One frame: start at step 0, results on steps res_first + k*res_stride
    // (k = 0..NINT-1) plus an optional extra result, optional starvation of
    // channel 5 from starve_step for starve_len cycles, optional stray starts.
    task automatic run_frame(input string name, input int res_first,
                             input int res_stride, input int extra_res,
                             input int starve_step, input int starve_len,
                             input int start_feed, input bit start_on_done,
                             input logic exp_err);
        int s, d, last12, gbase, rbase, dbase, n, stall_pos;
        int r, c, exp_cyc;
        logic [6:0] fbase;
        logic [5:0] idx;
        logic [NCH*DW-1:0] exp_pix;
        bit border;

        step();
        gbase  = got_data.size();
        rbase  = rd_count;
        dbase  = done_count;
        fbase  = rd_ptr;
        s      = cyc;
        last12 = res_first + (NINT - 1) * res_stride;
        stall_pos = starve_step - 1;
        d = s + 1 + NPIX + starve_len;
        if (s + last12 + 1 > d) d = s + last12 + 1;

        for (int i = 0; i < 90; i++) begin
            if (i > 0) step();
            start     = (i == 0) || (i == start_feed) || (start_on_done && i == d - s);
            res_valid = (i >= res_first && i <= last12 && ((i - res_first) % res_stride) == 0)
                        || (i == extra_res);
            starve_mask = '0;
            if (i >= starve_step && i < starve_step + starve_len) starve_mask[5] = 1'b1;
            #1;
            if (starve_mask != '0) chk_bit({name, "_starve_rdreq"}, fifo_rdreq, 1'b0);
            if (i == d - s) begin
                chk_bit({name, "_done_cycle_done"}, frame_done, 1'b1);
                chk_bit({name, "_done_cycle_busy"}, busy, 1'b1);
            end
            if (i == d - s + 1) begin
                chk_bit({name, "_after_done"}, frame_done, 1'b0);
                chk_bit({name, "_after_busy"}, busy, 1'b0);
            end
        end
        start = 1'b0;
        res_valid = 1'b0;
        starve_mask = '0;

        chk_int({name, "_pix_count"}, got_data.size() - gbase, NPIX);
        chk_int({name, "_read_count"}, rd_count - rbase, NINT);
        chk_int({name, "_done_pulses"}, done_count - dbase, 1);
        chk_int({name, "_done_at"}, done_cyc, d);
        chk_bit({name, "_err"}, err_overrun, exp_err);

        n = 0;
        for (int k = 0; k < NPIX; k++) begin
            r = k / int'(W + 2);
            c = k % int'(W + 2);
            border = (r == 0) || (r == int'(H + 1)) || (c == 0) || (c == int'(W + 1));
            if (border) begin
                exp_pix = '0;
            end else begin
                idx = 6'(int'(fbase) + n);
                exp_pix = mem[idx];
                n++;
            end
            exp_cyc = s + 2 + k;
            if (starve_len > 0 && k >= stall_pos) exp_cyc = exp_cyc + starve_len;
            if (gbase + k < got_data.size()) begin
                chk_vec($sformatf("%s_pix%0d_data", name, k), got_data[gbase + k], exp_pix);
                chk_int($sformatf("%s_pix%0d_cycle", name, k), got_cyc[gbase + k], exp_cyc);
            end
        end
    endtask

    initial begin
        int dbase;

        for (int i = 0; i < MEMN; i++) begin
            for (int ch = 0; ch < int'(NCH); ch++) begin
                mem[i][ch*DW +: DW] = $urandom;
            end
        end

        // Reset state
        step();
        step();
        chk_all_zero("reset");
        rst = 1'b1;

        // Frame abandoned by reset mid-FEED
        dbase = done_count;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk_bit("abort_busy_before", busy, 1'b1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk_all_zero("midframe_reset");
        for (int i = 0; i < 5; i++) step();
        chk_int("abort_no_done", done_count - dbase, 0);
        chk_bit("abort_idle", busy, 1'b0);

        // Full frame, FIFOs never empty; results partly during FEED
        run_frame("full", 20, 2, -1, 0, 0, -1, 1'b0, 1'b0);

        // Channel 5 starved at interior (1,1); results finish before the stream
        run_frame("starve", 10, 2, -1, 8, 10, -1, 1'b0, 1'b0);

        // Stray starts during FEED and on the DONE cycle
        run_frame("restart", 40, 1, -1, 0, 0, 5, 1'b1, 1'b0);

        // Result while idle
        step();
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        #1;
        chk_bit("idle_overrun", err_overrun, 1'b1);

        // All results during FEED plus a 13th: not counted, frame still ends once
        run_frame("overrun", 2, 1, 14, 0, 0, -1, 1'b0, 1'b1);
        step();
        chk_bit("overrun_sticky", err_overrun, 1'b1);

        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk_bit("overrun_cleared", err_overrun, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/featuremap_stream_ctrl.md
Name: featuremap_stream_ctrl

Overview:
- Frame sequencer in front of one conv layer's featuremap filter bank.
- Reads the NUM_CH per-channel input FIFOs in lockstep and inserts the 1-pixel zero border, producing a (WIDTH+2)x(HEIGHT+2) padded raster stream for the conv2D line buffers.
- Counts result pixels returned by the bias adder and signals frame completion to the layer scheduler.

Parameters:
- DATA_WIDTH, 32, IEEE-754 single word width.
- NUM_CH, 8, input channels read in lockstep.
- WIDTH, 56, unpadded feature map width.
- HEIGHT, 56, unpadded feature map height.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a frame when idle.
- fifo_empty  in  NUM_CH  per-channel FIFO empty flags (show-ahead FIFOs: data valid while not empty).
- fifo_data  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- fifo_rdreq  out  1  common read request to all channel FIFOs.
- pix_data  out  NUM_CH*DATA_WIDTH  padded pixel, same packing as fifo_data.
- pix_valid  out  1  pix_data valid this cycle.
- res_valid  in  1  result pixel valid from the bias adder.
- busy  out  1  high from accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last result.
- err_overrun  out  1  sticky: res_valid seen while IDLE or after count complete.

Behaviour:
- Reset (rst=0 at a clock edge) is synchronous and active-low. All outputs go to 0, state to IDLE, counters to 0, err_overrun cleared. Reset mid-frame abandons the frame; no frame_done is produced.
- States:
  - IDLE: start -> FEED; row=col=0, res_cnt=0.
  - FEED: walks padded positions row 0..HEIGHT+1 and col 0..WIDTH+1, raster order.
  - DRAIN: all positions issued, waiting for results.
  - DONE: one cycle, frame_done=1 -> IDLE.
- Border position: row==0, row==HEIGHT+1, col==0 or col==WIDTH+1.
  - Each border position costs exactly one cycle.
  - Next cycle: pix_valid=1, pix_data=0.
  - No FIFO read.
- Interior position:
  - fifo_rdreq = (state==FEED) & interior & ~|fifo_empty, combinational.
  - When fifo_rdreq=1, next cycle: pix_valid=1, pix_data=fifo_data as sampled, position advances.
  - Otherwise the position stalls, pix_valid=0 next cycle, no read.
  - A read never occurs with any channel empty; channels never desynchronise.
- Output timing: pix_* registered, latency 1 cycle from the position decision. Zeros and data share the same latency, so raster order is preserved.
- Position advance: col wraps WIDTH+1 -> 0 with row+1. The advance from (HEIGHT+1, WIDTH+1) goes to DRAIN.
- Stream size: exactly (WIDTH+2)*(HEIGHT+2) pix_valid pulses per frame, of which WIDTH*HEIGHT are FIFO reads.
- Result counting:
  - res_cnt counts res_valid in FEED and DRAIN; width $clog2(WIDTH*HEIGHT+1).
  - When res_cnt reaches WIDTH*HEIGHT and position issue is finished (DRAIN, or the same cycle the last position issues), go to DONE.
  - Results may arrive during FEED; this is normal.
- Overrun: res_valid in IDLE, DONE, or with res_cnt==WIDTH*HEIGHT sets err_overrun and is not counted. err_overrun clears only on reset.
- start while busy is ignored.
- start in the same cycle as DONE is ignored; it is accepted only in IDLE.
- busy = state != IDLE.

Decomposition:
- Shared package featuremap_pkg:
  - state enum (IDLE, FEED, DRAIN, DONE);
  - function for padded size (WIDTH+2)*(HEIGHT+2);
  - clog2 helper.
- Sub-module pad_raster_counter (row/col counter with wrap, border flag, last flag). Reused by pooling-layer padders.
- FSM, read gating and result counter stay in the top module.

Test Plan:
- Reset: WIDTH=4, HEIGHT=3; drive rst=0 mid-FEED -> next cycle all outputs 0, busy=0. A later start runs a full frame correctly.
- Full frame, FIFOs never empty: start -> 30 pix_valid pulses in 30 consecutive cycles beginning 1 cycle after start is accepted. Required values:
  - pixels 0-6 zero;
  - pixel 7 = first FIFO word;
  - exactly 12 fifo_rdreq pulses.
- Starvation: channel 5 empty for 10 cycles at interior (1,1) -> fifo_rdreq=0 and pix_valid=0 for those 10 cycles, no position advance. Resumes with correct data on all 8 channels.
- Completion: feed 12 res_valid, some during FEED and the rest after -> frame_done is exactly one pulse, the cycle after the 12th res_valid (or after the last position if later); busy falls with it.
- Overrun: res_valid in IDLE, and a 13th res_valid before DONE -> err_overrun=1 and stays 1; res_cnt unaffected; frame_done still a single pulse.
- start pulsed during FEED and on the DONE cycle -> ignored; no restart, no counter clear.
